alu_mp_seq: RTL and testbench

// - Initiator-side sequencer that drives one alu_para slice. Performs a wide
//   (BW*NW-bit) operation as NW consecutive BW-bit passes, LSW first, with carry chained.
// - Valid/ready handshake on both sides. Sits between the datapath controller
//   and a narrow ALU, so wide arithmetic needs no wide carry chain.

---
 rtl/alu_mp_seq_pkg.sv | 27 ++
 rtl/alu_mp_seq_if.sv | 51 +++++
 rtl/alu_para.sv | 47 ++++
 rtl/alu_mp_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_mp_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_mp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mp_seq_pkg
// Description : Shared definitions for the multi-pass ALU sequencer.
//               Holds the ALU opcode encodings used by alu_para and the
//               sequencer FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mp_seq_pkg;

    typedef logic [2:0] alu_op_t;
    typedef logic [1:0] state_t;

    // ALU opcodes. Bit 2 selects inverted B (subtract / compare).
    localparam alu_op_t OP_AND = 3'b000;
    localparam alu_op_t OP_OR  = 3'b001;
    localparam alu_op_t OP_ADD = 3'b010;
    localparam alu_op_t OP_SUB = 3'b110;
    localparam alu_op_t OP_SLT = 3'b111;

    // Sequencer FSM states
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage : alu_mp_seq_pkg
`default_nettype wire

// File: rtl/alu_mp_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_mp_seq_if
// Description : Request/response bundle of the multi-pass ALU sequencer.
//               Request side : in_valid/in_ready, in_a, in_b, in_op, in_cin
//               Response side: out_valid/out_ready, out_res, out_cout
//                              (+ out_zero when ALU_MP_ZERO_FLAG_EN is defined)
//               modport master : the requester / result consumer
//               modport slave  : the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_mp_seq_if #(
    parameter int BW = 32,
    parameter int NW = 4
);
    localparam int c_W = BW * NW;

    logic             in_valid;
    logic             in_ready;
    logic [c_W-1:0]   in_a;
    logic [c_W-1:0]   in_b;
    logic [2:0]       in_op;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [c_W-1:0]   out_res;
    logic             out_cout;
`ifdef ALU_MP_ZERO_FLAG_EN
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_res, out_cout, out_zero
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_res, out_cout, out_zero
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_res, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_res, out_cout
    );
`endif

endinterface : alu_mp_seq_if
`default_nettype wire

// File: rtl/alu_para.sv
`default_nettype none
// ============================================================================
// Module      : alu_para
// Description : Combinational BW-bit ALU slice with carry in/out.
//               Ports: a, b (BW) operands; op (3) opcode; c_in carry in;
//                      out (BW) result; c_out carry out of the adder.
//               The adder always runs (a + b' + c_in, b' = ~b when op[2]),
//               so c_out is the adder carry for every opcode, including
//               the logic ops.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_para
    import alu_mp_seq_pkg::*;
#(
    parameter int BW = 32
) (
    input  wire logic [BW-1:0] a,
    input  wire logic [BW-1:0] b,
    input  wire logic [2:0]    op,
    input  wire logic          c_in,
    output logic      [BW-1:0] out,
    output logic               c_out
);

    logic [BW-1:0] w_b_eff;
    logic [BW-1:0] w_sum;
    logic          w_carry;
    logic          w_ovf;

    assign w_b_eff = op[2] ? ~b : b;
    assign {w_carry, w_sum} = {1'b0, a} + {1'b0, w_b_eff} + (BW+1)'(c_in);
    // Signed overflow: operands agree in sign, result disagrees
    assign w_ovf = (a[BW-1] == w_b_eff[BW-1]) && (w_sum[BW-1] != a[BW-1]);
    assign c_out = w_carry;

    always_comb begin
        out = '0;
        case (op)
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_SLT:  out[0] = w_sum[BW-1] ^ w_ovf;
            default: out = w_sum;
        endcase
    end

endmodule : alu_para
`default_nettype wire

// File: rtl/alu_mp_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mp_seq
// Description : Initiator-side sequencer driving one alu_para slice. A wide
//               (BW*NW) operation is executed as NW consecutive BW-bit
//               passes, least significant word first, with the carry chained
//               through a register between passes.
//               Ports: clk, rst (sync, active high), bus (alu_mp_seq_if.slave)
//               Config macro: ALU_MP_ZERO_FLAG_EN adds bus.out_zero, set
//               when every result bit of the wide operation is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mp_seq
    import alu_mp_seq_pkg::*;
#(
    parameter int BW = 32,
    parameter int NW = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    alu_mp_seq_if.slave  bus
);

    localparam int c_W  = BW * NW;
    localparam int c_KW = (NW < 2) ? 1 : $clog2(NW + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_W-1:0]  r_a;
    logic [c_W-1:0]  r_b;
    logic [2:0]      r_op;
    logic            r_carry;
    logic            r_cout;
    logic [c_KW-1:0] r_k;
    logic [c_W-1:0]  r_res;
    logic [c_W-1:0]  w_res_nxt;
    logic [BW-1:0]   w_a_slice;
    logic [BW-1:0]   w_b_slice;
    logic [BW-1:0]   w_alu_out;
    logic            w_alu_cout;
    logic            w_accept;
    logic            w_run;
    logic            w_last;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = (r_k == c_KW'(NW - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.out_res   = r_res;
        bus.out_cout  = r_cout;
    end

    // ------------------------------------------------------------------
    // Slice select: operand words for pass k and the result with word k
    // replaced. Constant-index muxes keep every part-select static.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        w_res_nxt = r_res;
        for (int i = 0; i < NW; i++) begin
            if (r_k == c_KW'(i)) begin
                w_a_slice                = r_a[i*BW +: BW];
                w_b_slice                = r_b[i*BW +: BW];
                w_res_nxt[i*BW +: BW]    = w_alu_out;
            end
        end
    end

    alu_para #(
        .BW (BW)
    ) u_alu (
        .a     (w_a_slice),
        .b     (w_b_slice),
        .op    (r_op),
        .c_in  (r_carry),
        .out   (w_alu_out),
        .c_out (w_alu_cout)
    );

    // ------------------------------------------------------------------
    // Datapath: operand capture, carry chain, result assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_k     <= '0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_op    <= bus.in_op;
            r_carry <= bus.in_cin;
            r_k     <= '0;
        end else if (w_run) begin
            r_res   <= w_res_nxt;
            r_carry <= w_alu_cout;
            // k counts up to NW at most, which fits in c_KW bits
            r_k     <= r_k + c_KW'(1);
            if (w_last) begin
                r_cout <= w_alu_cout;
            end
        end
    end

`ifdef ALU_MP_ZERO_FLAG_EN
    // ------------------------------------------------------------------
    // Zero flag: OR-accumulate every slice result, resolve on last pass
    // ------------------------------------------------------------------
    logic r_nz;
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_nz   <= 1'b0;
        end else if (w_run) begin
            r_nz <= r_nz | (|w_alu_out);
            if (w_last) begin
                r_zero <= ~(r_nz | (|w_alu_out));
            end
        end
    end

    assign bus.out_zero = r_zero;
`endif

endmodule : alu_mp_seq
`default_nettype wire

// File: tb/tb_alu_mp_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mp_seq
// Description : Self-checking bench for alu_mp_seq with BW=4, NW=2.
//               Table of directed vectors plus hand-written sequences for
//               backpressure and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mp_seq;
    import alu_mp_seq_pkg::*;

    localparam int BW = 4;
    localparam int NW = 2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;

    alu_mp_seq_if #(.BW(BW), .NW(NW)) bus ();

    alu_mp_seq #(
        .BW (BW),
        .NW (NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op, input logic cin,
                                input logic [7:0] res, input logic cout,
                                input string name);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.cin = cin;
        v.res = res; v.cout = cout; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction with exact latency checks. out_ready is held
    // high throughout, so it must not matter while out_valid is low.
    task automatic run_op(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({v.name, "_ready_timeout"}, 32'd0, 32'd1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.in_op     = v.op;
        bus.in_cin    = v.cin;
        @(negedge clk);                       // accept edge T has passed
        bus.in_valid  = 1'b0;
        // Scramble inputs: the result must come from captured operands
        bus.in_a      = ~v.a;
        bus.in_b      = 8'h5A;
        bus.in_op     = OP_OR;
        bus.in_cin    = ~v.cin;
        check({v.name, "_ready_low"}, 32'(bus.in_ready), 32'd0);
        check({v.name, "_valid_T"},   32'(bus.out_valid), 32'd0);
        for (int i = 1; i < NW; i++) begin
            @(negedge clk);
            check({v.name, "_valid_early"}, 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);                       // edge T+NW has passed
        check({v.name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({v.name, "_res"},   32'(bus.out_res),   32'(v.res));
        check({v.name, "_cout"},  32'(bus.out_cout),  32'(v.cout));
`ifdef ALU_MP_ZERO_FLAG_EN
        check({v.name, "_zero"},  32'(bus.out_zero),  32'(v.res == 8'h00));
`endif
        @(negedge clk);
        check({v.name, "_exit_valid"}, 32'(bus.out_valid), 32'd0);
        check({v.name, "_exit_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_AND;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res",   32'(bus.out_res),   32'h00);
        check("rst_out_cout",  32'(bus.out_cout),  32'd0);
`ifdef ALU_MP_ZERO_FLAG_EN
        check("rst_out_zero",  32'(bus.out_zero),  32'd0);
`endif
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        vecs[0] = mk(8'h3F, 8'h01, OP_ADD, 1'b0, 8'h40, 1'b0, "add");
        vecs[1] = mk(8'hFF, 8'h01, OP_ADD, 1'b0, 8'h00, 1'b1, "add_wrap");
        vecs[2] = mk(8'h10, 8'h01, OP_SUB, 1'b1, 8'h0F, 1'b1, "sub");
        vecs[3] = mk(8'h01, 8'h02, OP_SUB, 1'b1, 8'hFF, 1'b0, "sub_borrow");
        vecs[4] = mk(8'h50, 8'h0A, OP_OR,  1'b0, 8'h5A, 1'b0, "or");
        vecs[5] = mk(8'hC3, 8'h0F, OP_AND, 1'b0, 8'h03, 1'b0, "and");
        vecs[6] = mk(8'h0F, 8'h01, OP_ADD, 1'b1, 8'h11, 1'b0, "add_cin");
        foreach (vecs[i]) run_op(vecs[i]);

        // ---------------- backpressure ----------------
        begin
            int n;
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_a      = 8'h3F;
            bus.in_b      = 8'h01;
            bus.in_op     = OP_ADD;
            bus.in_cin    = 1'b0;
            @(negedge clk);
            bus.in_valid  = 1'b0;
            n = 0;
            while (!bus.out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
            for (int c = 0; c < 5; c++) begin
                // Pulsed requests during the stall must be ignored
                bus.in_valid = (c % 2 == 0);
                bus.in_a     = 8'h11;
                bus.in_b     = 8'h22;
                @(negedge clk);
                check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_res",   32'(bus.out_res),   32'h40);
                check("bp_hold_cout",  32'(bus.out_cout),  32'd0);
                check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("bp_release_valid", 32'(bus.out_valid), 32'd0);
            check("bp_release_ready", 32'(bus.in_ready),  32'd1);
            @(negedge clk);
            check("bp_no_ghost_op", 32'(bus.in_ready), 32'd1);
        end
        run_op(mk(8'hFF, 8'h01, OP_ADD, 1'b0, 8'h00, 1'b1, "bp_resume"));

        // ---------------- abort during RUN ----------------
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h7E;
        bus.in_b     = 8'h31;
        bus.in_op    = OP_ADD;
        bus.in_cin   = 1'b0;
        @(negedge clk);                       // now in RUN
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        check("abort_ready", 32'(bus.in_ready),  32'd1);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_res",   32'(bus.out_res),   32'h00);
        check("abort_cout",  32'(bus.out_cout),  32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_stay_idle", 32'(bus.out_valid), 32'd0);
        end
        run_op(mk(8'h01, 8'h01, OP_ADD, 1'b0, 8'h02, 1'b0, "post_abort"));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_mp_seq
`default_nettype wire
